powerup_scheduler: RTL and testbench

POWERUP_SCHEDULER -- requirements
Module: powerup_scheduler

---
 rtl/pong_pkg.sv | 34 +++
 rtl/pp_slot_timer.sv | 41 ++++
 rtl/powerup_scheduler.sv | 168 ++++++++++++++++
 tb/tb_powerup_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and default constants for the powerup scheduler.
package pong_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_SPAWNED = 2'd3
  } state_e;

  // Powerup modes; the encoding doubles as the status-bit index.
  typedef enum logic [1:0] {
    MODE_PP1 = 2'd0,
    MODE_PP2 = 2'd1,
    MODE_PP3 = 2'd2,
    MODE_PP4 = 2'd3
  } mode_e;

  localparam int PRESCALER_DEF   = 64999999;
  localparam int SPAWN_DELAY_DEF = 2;
  localparam int PP1_TIME_DEF    = 3;
  localparam int PP2_TIME_DEF    = 2;
  localparam int PP3_TIME_DEF    = 5;
  localparam int PP4_TIME_DEF    = 4;

  localparam logic [3:0] LFSR_SEED = 4'b1001;

  // One step of the x^4+x^3+1 Fibonacci LFSR; a nonzero state never reaches 0.
  function automatic logic [3:0] lfsr4_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

endpackage

// File: rtl/pp_slot_timer.sv
// One loadable, tick-decremented, saturating 4-bit powerup timer.
module pp_slot_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       tick,
  output logic       active
);

  logic [3:0] count_q, count_d;
  logic       active_q, active_d;

  // Clear beats load, load beats tick; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
    active_d = (count_d != 4'd0);
  end

  // Remaining time and its registered nonzero flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= 4'd0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;

endmodule

// File: rtl/powerup_scheduler.sv
// Spawns a random powerup after a delay, arbitrates who ate it, and
// runs one duration timer per (player, mode).
module powerup_scheduler
  import pong_pkg::*;
#(
  parameter int PRESCALER   = PRESCALER_DEF,
  parameter int SPAWN_DELAY = SPAWN_DELAY_DEF,
  parameter int PP1_TIME    = PP1_TIME_DEF,
  parameter int PP2_TIME    = PP2_TIME_DEF,
  parameter int PP3_TIME    = PP3_TIME_DEF,
  parameter int PP4_TIME    = PP4_TIME_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_active,
  input  logic       eaten_p1,
  input  logic       eaten_p2,
  output logic       spawn_valid,
  output logic [1:0] spawn_mode,
  output logic       grant,
  output logic       grant_owner,
  output logic [3:0] pp_status_p1,
  output logic [3:0] pp_status_p2
);

  logic [25:0] presc_q, presc_d;
  logic        tick;
  logic [3:0]  lfsr_q, lfsr_d;
  state_e      state_q, state_d;
  logic [3:0]  delay_q, delay_d;
  logic        spawn_valid_q, spawn_valid_d;
  mode_e       spawn_mode_q, spawn_mode_d;
  logic        grant_q, grant_d;
  logic        grant_owner_q, grant_owner_d;
  logic        last_owner_q, last_owner_d;
  logic        load_fire;
  logic        win_owner;
  logic [7:0]  slot_active;

  // 1 Hz prescaler: runs only during a rally, otherwise parked at zero.
  always_comb begin
    presc_d = 26'd0;
    if (game_active) begin
      presc_d = (presc_q == 26'(PRESCALER)) ? 26'd0 : presc_q + 26'd1;
    end
  end

  assign tick = game_active && (presc_q == 26'(PRESCALER));

  // Free-running mode generator.
  always_comb begin
    lfsr_d = lfsr4_next(lfsr_q);
  end

  // On a tie the player who did not win last time gets it.
  assign win_owner = (eaten_p1 && eaten_p2) ? ~last_owner_q : eaten_p2;

  // Scheduler next-state and output logic; losing the rally overrides all.
  always_comb begin
    state_d       = state_q;
    delay_d       = delay_q;
    spawn_valid_d = spawn_valid_q;
    spawn_mode_d  = spawn_mode_q;
    grant_d       = 1'b0;
    grant_owner_d = grant_owner_q;
    last_owner_d  = last_owner_q;
    load_fire     = 1'b0;
    if (!game_active) begin
      state_d       = ST_IDLE;
      delay_d       = 4'd0;
      spawn_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
        end
        ST_ARM: begin
          delay_d = 4'(SPAWN_DELAY);
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (tick) begin
            if (delay_q <= 4'd1) begin
              delay_d       = 4'd0;
              spawn_mode_d  = mode_e'(lfsr_q[1:0]);
              spawn_valid_d = 1'b1;
              state_d       = ST_SPAWNED;
            end else begin
              delay_d = delay_q - 4'd1;
            end
          end
        end
        ST_SPAWNED: begin
          if (eaten_p1 || eaten_p2) begin
            grant_d       = 1'b1;
            grant_owner_d = win_owner;
            last_owner_d  = win_owner;
            load_fire     = 1'b1;
            spawn_valid_d = 1'b0;
            state_d       = ST_ARM;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q       <= 26'd0;
      lfsr_q        <= LFSR_SEED;
      state_q       <= ST_IDLE;
      delay_q       <= 4'd0;
      spawn_valid_q <= 1'b0;
      spawn_mode_q  <= MODE_PP1;
      grant_q       <= 1'b0;
      grant_owner_q <= 1'b0;
      last_owner_q  <= 1'b1;
    end else begin
      presc_q       <= presc_d;
      lfsr_q        <= lfsr_d;
      state_q       <= state_d;
      delay_q       <= delay_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_mode_q  <= spawn_mode_d;
      grant_q       <= grant_d;
      grant_owner_q <= grant_owner_d;
      last_owner_q  <= last_owner_d;
    end
  end

  // Slot index = owner*4 + mode, so the low nibble is player 1.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      localparam logic [1:0] SLOT_MODE  = 2'(gi % 4);
      localparam logic       SLOT_OWNER = 1'(gi / 4);
      localparam int         SLOT_DUR   = ((gi % 4) == 0) ? PP1_TIME :
                                          ((gi % 4) == 1) ? PP2_TIME :
                                          ((gi % 4) == 2) ? PP3_TIME : PP4_TIME;
      logic slot_load;

      assign slot_load = load_fire && (win_owner == SLOT_OWNER) &&
                         (spawn_mode_q == SLOT_MODE);

      pp_slot_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (!game_active),
        .load     (slot_load),
        .load_val (4'(SLOT_DUR)),
        .tick     (tick),
        .active   (slot_active[gi])
      );
    end
  endgenerate

  assign spawn_valid  = spawn_valid_q;
  assign spawn_mode   = spawn_mode_q;
  assign grant        = grant_q;
  assign grant_owner  = grant_owner_q;
  assign pp_status_p1 = slot_active[3:0];
  assign pp_status_p2 = slot_active[7:4];

endmodule

// File: tb/tb_powerup_scheduler.sv
// Randomized bench for powerup_scheduler with a behavioural reference model.
module tb_powerup_scheduler;

  localparam int PRESC = 3;

  logic       clk;
  logic       reset;
  logic       game_active;
  logic       eaten_p1;
  logic       eaten_p2;
  logic       spawn_valid;
  logic [1:0] spawn_mode;
  logic       grant;
  logic       grant_owner;
  logic [3:0] pp_status_p1;
  logic [3:0] pp_status_p2;

  int n_checks = 0;
  int n_pass   = 0;

  powerup_scheduler #(.PRESCALER(PRESC)) dut (
    .clk          (clk),
    .reset        (reset),
    .game_active  (game_active),
    .eaten_p1     (eaten_p1),
    .eaten_p2     (eaten_p2),
    .spawn_valid  (spawn_valid),
    .spawn_mode   (spawn_mode),
    .grant        (grant),
    .grant_owner  (grant_owner),
    .pp_status_p1 (pp_status_p1),
    .pp_status_p2 (pp_status_p2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // LFSR value after n edges since reset is LFSR_SEQ[n % 15].
  int LFSR_SEQ [15] = '{9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1, 2, 4};
  int DUR [4]       = '{3, 2, 5, 4};
  int SPAWN_DLY     = 2;

  int         m_phase;     // 0 idle, 1 arming, 2 waiting, 3 on field
  int         m_delay;
  int         m_run;       // consecutive active edges: prescaler phase
  int         m_edges;     // edges since reset: LFSR position
  int         m_timer [8]; // remaining seconds, index owner*4+mode
  logic       m_sv, m_grant, m_owner, m_last, m_tick;
  logic [1:0] m_mode;
  int         m_w;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_delay = 0; m_run = 0; m_edges = 0;
      for (int i = 0; i < 8; i++) m_timer[i] = 0;
      m_sv = 0; m_grant = 0; m_owner = 0; m_last = 1; m_mode = 0;
    end else begin
      m_tick  = game_active && ((m_run % (PRESC + 1)) == PRESC);
      m_grant = 0;
      if (!game_active) begin
        m_phase = 0; m_delay = 0; m_sv = 0; m_run = 0;
        for (int i = 0; i < 8; i++) m_timer[i] = 0;
      end else begin
        for (int i = 0; i < 8; i++)
          if (m_tick && m_timer[i] > 0) m_timer[i] = m_timer[i] - 1;
        case (m_phase)
          0: m_phase = 1;
          1: begin m_delay = SPAWN_DLY; m_phase = 2; end
          2: if (m_tick) begin
               m_delay = m_delay - 1;
               if (m_delay == 0) begin
                 m_mode  = 2'(LFSR_SEQ[m_edges % 15] % 4);
                 m_sv    = 1;
                 m_phase = 3;
               end
             end
          default: if (eaten_p1 || eaten_p2) begin
               m_w = (eaten_p1 && eaten_p2) ? (m_last ? 0 : 1) : (eaten_p2 ? 1 : 0);
               m_grant = 1;
               m_owner = 1'(m_w);
               m_last  = 1'(m_w);
               m_timer[m_w * 4 + int'(m_mode)] = DUR[m_mode];
               m_sv    = 0;
               m_phase = 1;
               $display("grant owner=%0d mode=%0d t=%0t", m_w, m_mode, $time);
             end
        endcase
        m_run = m_run + 1;
      end
      m_edges = m_edges + 1;
    end
  end

  // Every cycle out of reset, the whole output bundle must match the model.
  always @(negedge clk) begin
    logic [3:0] e1, e2;
    if (reset) begin
      for (int m = 0; m < 4; m++) begin
        e1[m] = (m_timer[m] != 0);
        e2[m] = (m_timer[4 + m] != 0);
      end
      check("cycle_outputs",
            32'({spawn_valid, spawn_mode, grant, grant_owner, pp_status_p1, pp_status_p2}),
            32'({m_sv, m_mode, m_grant, m_owner, e1, e2}));
    end
  end

  task automatic wait_spawn(input int budget);
    int n = 0;
    while (!spawn_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("spawn_wait", 32'(spawn_valid), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int low_cnt;
    reset = 1'b0; game_active = 1'b0; eaten_p1 = 1'b0; eaten_p2 = 1'b0;

    #12;
    check("reset_outputs",
          32'({spawn_valid, spawn_mode, grant, grant_owner, pp_status_p1, pp_status_p2}), 32'd0);
    game_active = 1'b1;
    #10 reset = 1'b1;

    // First spawn: two ticks into the rally, mode from LFSR after 7 steps (0111).
    n = 0;
    while (!spawn_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("spawn_latency_edges", 32'(n), 32'd8);
    check("first_spawn_mode", 32'(spawn_mode), 32'd3);

    // Tie on the first grant goes to player 1.
    eaten_p1 = 1'b1; eaten_p2 = 1'b1;
    @(negedge clk);
    eaten_p1 = 1'b0; eaten_p2 = 1'b0;
    check("tie1_grant", 32'(grant), 32'd1);
    check("tie1_owner", 32'(grant_owner), 32'd0);
    check("tie1_status_p1", 32'(pp_status_p1), 32'h8);
    @(negedge clk);
    check("grant_one_cycle", 32'(grant), 32'd0);

    // Second tie goes to player 2; mode from LFSR wrapped to seed (1001).
    wait_spawn(40);
    check("second_spawn_mode", 32'(spawn_mode), 32'd1);
    eaten_p1 = 1'b1; eaten_p2 = 1'b1;
    @(negedge clk);
    eaten_p1 = 1'b0; eaten_p2 = 1'b0;
    check("tie2_owner", 32'(grant_owner), 32'd1);
    check("tie2_status_p2", 32'(pp_status_p2), 32'h2);
    check("p1_still_active", 32'(pp_status_p1), 32'h8);

    // Drop the rally during WAIT: everything clears, eating is ignored.
    @(negedge clk);
    game_active = 1'b0;
    @(negedge clk);
    check("drop_clears_p1", 32'(pp_status_p1), 32'd0);
    check("drop_clears_p2", 32'(pp_status_p2), 32'd0);
    eaten_p1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_no_grant", 32'(grant), 32'd0);
    end
    eaten_p1 = 1'b0;
    game_active = 1'b1;

    // Random rallies and eats.
    low_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (low_cnt > 0) begin
        game_active = 1'b0;
        low_cnt--;
      end else if ($urandom_range(0, 299) == 0) begin
        game_active = 1'b0;
        low_cnt = $urandom_range(1, 6);
      end else begin
        game_active = 1'b1;
      end
      eaten_p1 = ($urandom_range(0, 3) == 0);
      eaten_p2 = ($urandom_range(0, 3) == 0);
    end

    // Asynchronous reset in the middle of SPAWNED.
    @(posedge clk);
    #1;
    game_active = 1'b1; eaten_p1 = 1'b0; eaten_p2 = 1'b0;
    wait_spawn(60);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_spawn_valid", 32'(spawn_valid), 32'd0);
    check("async_reset_grant", 32'(grant), 32'd0);
    #20;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
